// File: rtl/codificador_teclado.sv
`timescale 1ns/1ps
// codificador_teclado
//   Keypad-side front end for the microwave countdown timer. Debounces a
//   10-key one-hot keypad, encodes each accepted key to BCD, strobes it into
//   the counter and sequences the entry / run / pause control.
//
//   Optional feature macro: KEY_BEEP_EN (beep pulse generator). When it is
//   undefined the beep output is tied low and the port list is unchanged.
//
// Ports
//   clock       in   system clock, rising edge
//   clrn        in   asynchronous active-low reset
//   keypad[9:0] in   key k pressed when bit k = 1
//   start_n     in   start/resume key, active low, synchronous
//   stop_n      in   pause/clear key, active low, synchronous
//   timer_done  in   countdown reached 0:00
//   data[3:0]   out  BCD of the last accepted key
//   load_stb    out  one-cycle strobe, counter shifts data in
//   loadn       out  0 = entry mode, 1 = counting mode (registered)
//   enable      out  countdown enable (registered)
//   digits[1:0] out  keys accepted since last clear, saturating
//   err         out  more than one keypad bit set (combinational)
//   beep        out  audible pulse
module codificador_teclado #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 3,
  parameter int BEEP_CYCLES     = 8
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic [9:0] keypad,
  input  logic       start_n,
  input  logic       stop_n,
  input  logic       timer_done,
  output logic [3:0] data,
  output logic       load_stb,
  output logic       loadn,
  output logic       enable,
  output logic [1:0] digits,
  output logic       err,
  output logic       beep
);

  typedef enum logic [2:0] {
    ST_ENTRY, ST_DEBOUNCE, ST_EMIT, ST_RELEASE, ST_RUN, ST_PAUSE
  } state_t;

  localparam logic [3:0] CNT_LAST   = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] DIGITS_MAX = 2'(MAX_DIGITS);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;          // consecutive stable samples seen so far
  logic [9:0] pattern, pattern_next;  // keypad pattern captured on first sample
  logic [3:0] data_next;
  logic [1:0] digits_next;
  logic       stb_next;
  logic       one_hot;
  logic       multi_hot;

  function automatic logic [3:0] key_to_bcd(input logic [9:0] k);
    logic [3:0] bcd;
    bcd = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) bcd = 4'(i);
    end
    return bcd;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = (keypad & (keypad - 10'd1)) != 10'd0;
  assign one_hot   = (keypad != 10'd0) && !multi_hot;
  assign err       = multi_hot;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pattern_next = pattern;
    data_next    = data;
    digits_next  = digits;
    stb_next     = 1'b0;
    case (state)
      ST_ENTRY: begin
        if (!stop_n) begin
          digits_next = 2'd0;
        end else if (!start_n && digits != 2'd0) begin
          state_next = ST_RUN;
        end else if (one_hot) begin
          state_next   = ST_DEBOUNCE;
          cnt_next     = 4'd0;
          pattern_next = keypad;
        end
      end
      ST_DEBOUNCE: begin
        if (keypad != pattern) begin
          state_next = ST_ENTRY;
        end else if (cnt == CNT_LAST) begin
          // Strobe, data and digit count all register on the edge into EMIT
          // so they are coherent during the single EMIT cycle.
          state_next  = ST_EMIT;
          stb_next    = 1'b1;
          data_next   = key_to_bcd(pattern);
          digits_next = (digits >= DIGITS_MAX) ? DIGITS_MAX : digits + 2'd1;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      ST_EMIT: begin
        state_next = ST_RELEASE;
        cnt_next   = 4'd0;
      end
      ST_RELEASE: begin
        if (keypad != 10'd0) begin
          cnt_next = 4'd0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_ENTRY;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      ST_RUN: begin
        if (timer_done) begin
          state_next  = ST_ENTRY;
          digits_next = 2'd0;
        end else if (!stop_n) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (!stop_n) begin
          state_next  = ST_ENTRY;
          digits_next = 2'd0;
        end else if (!start_n) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_ENTRY;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state    <= ST_ENTRY;
      cnt      <= 4'd0;
      pattern  <= 10'd0;
      data     <= 4'd0;
      digits   <= 2'd0;
      load_stb <= 1'b0;
      loadn    <= 1'b0;
      enable   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      pattern  <= pattern_next;
      data     <= data_next;
      digits   <= digits_next;
      load_stb <= stb_next;
      // Registered from the next state so they change with the state itself.
      loadn    <= (state_next == ST_RUN) || (state_next == ST_PAUSE);
      enable   <= (state_next == ST_RUN);
    end
  end

`ifdef KEY_BEEP_EN
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  logic [BW-1:0] beep_cnt;
  logic          beep_trig;

  // Leaving EMIT starts the pulse the cycle after the strobe; the timer_done
  // exit from RUN starts it together with the return to ENTRY.
  assign beep_trig = (state == ST_EMIT) || (state == ST_RUN && timer_done);

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      beep_cnt <= '0;
    end else if (beep_trig) begin
      beep_cnt <= BW'(BEEP_CYCLES);
    end else if (beep_cnt != '0) begin
      beep_cnt <= beep_cnt - BW'(1);
    end
  end

  assign beep = (beep_cnt != '0);
`else
  assign beep = 1'b0;
`endif

endmodule

// File: doc/codificador_teclado.md
Name: codificador_teclado

Overview:
- Keypad-side front end for the microwave timer countdown counter.
- Debounces and validates a 10-key one-hot keypad, encodes each accepted key to BCD, and presents it on data with a one-cycle load_stb.
- load_stb drives the counter's digit-shift clock while loadn is low.
- Sequences the start/pause/clear/done control: loadn and enable for the counter, reacting to its timer_done.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a press or a release (range 2..15).
- MAX_DIGITS, 3, saturation value of the digits counter (mins, sec_tens, sec_ones).
- BEEP_CYCLES, 8, beep pulse length in clocks (used only with KEY_BEEP_EN).

Ports:
- clock  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- keypad  in  10  key k pressed when bit k = 1 (k = 0..9).
- start_n  in  1  start/resume key, active low, already synchronous.
- stop_n  in  1  pause/clear key, active low, already synchronous.
- timer_done  in  1  countdown reached 0:00, from the counter.
- data  out  4  BCD of the last accepted key.
- load_stb  out  1  one-cycle strobe; the counter shifts data in.
- loadn  out  1  0 = entry mode, 1 = counting mode.
- enable  out  1  countdown enable to the counter.
- digits  out  2  keys accepted since the last clear, saturating at MAX_DIGITS.
- err  out  1  high while more than one keypad bit is set.
- beep  out  1  audible pulse (see Optional Feature).

Behaviour:
- Reset (clrn=0, asynchronous): state ENTRY; data=0, load_stb=0, loadn=0, enable=0, digits=0, err=0, beep=0, debounce counter=0.
- States: ENTRY, DEBOUNCE, EMIT, RELEASE, RUN, PAUSE.
- ENTRY:
  - loadn=0, enable=0.
  - Exactly one keypad bit set → DEBOUNCE, counter cleared.
  - start_n=0 with digits>0 → RUN.
  - start_n=0 with digits=0 → ignored.
  - stop_n=0 → digits=0, stay in ENTRY.
- DEBOUNCE:
  - Pattern must equal the first-sampled pattern for DEBOUNCE_CYCLES consecutive rising edges, then → EMIT.
  - Any change (including release or multi-hot) → ENTRY with no emission.
  - start_n and stop_n are ignored.
- EMIT, exactly one cycle:
  - data = BCD of the key.
  - load_stb=1.
  - digits = min(digits+1, MAX_DIGITS).
  - → RELEASE.
- Latency: with key stable from cycle 0, load_stb is high in cycle DEBOUNCE_CYCLES+1.
- data holds its value until the next EMIT or reset.
- RELEASE: keypad must read all-zero for DEBOUNCE_CYCLES consecutive edges → ENTRY. Holding a key never produces a second strobe.
- Keys accepted beyond MAX_DIGITS are still emitted, because the counter drops the oldest digit; digits stays at MAX_DIGITS.
- RUN:
  - loadn=1, enable=1; keypad is ignored.
  - timer_done=1 → ENTRY, digits=0.
  - stop_n=0 → PAUSE.
- PAUSE:
  - loadn=1, enable=0.
  - start_n=0 → RUN.
  - stop_n=0 → ENTRY, digits=0.
- Simultaneous events:
  - stop_n beats start_n in every state.
  - In RUN, timer_done beats stop_n.
- err = 1 combinationally whenever popcount(keypad) > 1, in any state.
- load_stb is never asserted outside EMIT. The loadn and enable outputs are registered.

Optional Feature:
- Macro: KEY_BEEP_EN.
- Defined: beep goes high for BEEP_CYCLES clocks starting the cycle after EMIT, and again on the RUN→ENTRY transition caused by timer_done. A new trigger restarts the count.
- Undefined: beep is tied to 0, no beep counter is synthesised, and the port list is unchanged.

Test Plan:
- Reset mid-DEBOUNCE (clrn pulse 0.5 cycle) → all outputs return to reset values immediately and no load_stb follows.
- Keys 2,1,7,9 each held 6 cycles and released 6 cycles (DEBOUNCE_CYCLES=4) → four load_stb pulses with data 2,1,7,9; digits ends at 3; loadn=0 throughout.
- keypad = 10'b0000000110 → err=1, no load_stb. Bounce 1→0→1 within 3 cycles → no load_stb.
- After entry, start_n low 1 cycle → next cycle loadn=1, enable=1. Then stop_n → enable=0, loadn=1. Then start_n → enable=1. Then stop_n twice → ENTRY with digits=0.
- In RUN, assert timer_done and stop_n in the same cycle → ENTRY with digits=0, enable=0; beep high for 8 cycles when KEY_BEEP_EN is defined, 0 otherwise.
- start_n low with digits=0 → remains in ENTRY with enable=0. Hold key 5 for 50 cycles → exactly one load_stb.
